xbar_pkt_scheduler: RTL and testbench

- Packet-level scheduler for the 4-port crossbar. It allocates output ports to input head packets for the whole packet duration, including multicast with all-or-nothing allocation.
- It paces beat transfer against output backpressure and drives the crossbar mux selects.
- It sits between the input FIFOs and the output-port muxes. Allocation fairness is provided by a global round-robin pointer over inputs.

---
 rtl/xbar_pkt_scheduler_if.sv | 26 ++
 rtl/xbar_pkt_scheduler.sv | 173 +++++++++++++++++
 tb/tb_xbar_pkt_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_pkt_scheduler_if.sv
// Bundle between the input FIFOs, the packet scheduler and the output-port muxes.
// The scheduler sits on the slave side. The FIFO/mux side, or a bench, sits on the master side.
interface xbar_pkt_scheduler_if #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_WIDTH = 6
) ();
  logic [NUM_PORTS-1:0]           in_valid;
  logic [NUM_PORTS*NUM_PORTS-1:0] in_dst;
  logic [NUM_PORTS*LEN_WIDTH-1:0] in_len;
  logic [NUM_PORTS-1:0]           out_ready;
  logic [NUM_PORTS-1:0]           in_pop;
  logic [NUM_PORTS-1:0]           in_drop;
  logic [NUM_PORTS-1:0]           busy_in;
  logic [NUM_PORTS*2-1:0]         mux_sel;
  logic [NUM_PORTS-1:0]           out_active;
  logic [NUM_PORTS-1:0]           out_eop;

  modport master (
    output in_valid, in_dst, in_len, out_ready,
    input  in_pop, in_drop, busy_in, mux_sel, out_active, out_eop
  );
  modport slave (
    input  in_valid, in_dst, in_len, out_ready,
    output in_pop, in_drop, busy_in, mux_sel, out_active, out_eop
  );
endinterface

// File: rtl/xbar_pkt_scheduler.sv
// Packet-level scheduler for the 4-port crossbar. Each input lane holds its head packet's mask and
// length. The top allocates outputs all-or-nothing under a global round-robin pointer.

module xbar_pkt_lane #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [NUM_PORTS-1:0] dst,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 grant,
  input  logic [NUM_PORTS-1:0] out_ready,
  output logic                 req,
  output logic                 drop,
  output logic                 pop,
  output logic                 last,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] mask
);
  typedef enum logic {IDLE, XFER} state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 legal;

  assign legal = (dst != '0) && (len != '0);
  assign req   = (state_q == IDLE) && valid && legal;
  // Gated by reset so an illegal head seen during reset is not reported.
  assign drop  = rst_n && (state_q == IDLE) && valid && !legal;
  // A beat moves only when every masked output can take it (lockstep multicast).
  assign pop   = (state_q == XFER) && ((mask_q & ~out_ready) == '0);
  assign last  = pop && (rem_q == LEN_WIDTH'(1));
  assign busy  = (state_q == XFER);
  assign mask  = mask_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = XFER;
        mask_d  = dst;
        rem_d   = len;
      end
      XFER: if (pop) begin
        rem_d = rem_q - LEN_WIDTH'(1);
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
    end
  end
endmodule

module xbar_pkt_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_WIDTH = 6
) (
  input logic                 clk,
  input logic                 rst_n,
  xbar_pkt_scheduler_if.slave bus
);
  localparam int PW = 2;

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] dst, lane_mask;
  logic [NUM_PORTS-1:0][LEN_WIDTH-1:0] len;
  logic [NUM_PORTS-1:0] req, grant, drop, pop, last, busy;
  logic [NUM_PORTS-1:0] claimed, owned_q, owned_d, active, eop;
  logic [NUM_PORTS-1:0][PW-1:0] owner_q, owner_d, sel;
  logic [PW-1:0] rr_q, rr_d, idx;
  logic          found;

  assign dst = bus.in_dst;
  assign len = bus.in_len;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    xbar_pkt_lane #(.NUM_PORTS(NUM_PORTS), .LEN_WIDTH(LEN_WIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (bus.in_valid[i]),
      .dst       (dst[i]),
      .len       (len[i]),
      .grant     (grant[i]),
      .out_ready (bus.out_ready),
      .req       (req[i]),
      .drop      (drop[i]),
      .pop       (pop[i]),
      .last      (last[i]),
      .busy      (busy[i]),
      .mask      (lane_mask[i])
    );
  end

  // Every requester claims its mask, even when blocked, so a waiting multicast
  // cannot be starved by later-scanned unicast.
  always_comb begin
    claimed = '0;
    grant   = '0;
    found   = 1'b0;
    rr_d    = rr_q;
    idx     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_q + PW'(k);
      if (req[idx]) begin
        if ((dst[idx] & (owned_q | claimed)) == '0) begin
          grant[idx] = 1'b1;
          if (!found) begin
            rr_d  = idx + PW'(1);
            found = 1'b1;
          end
        end
        claimed = claimed | dst[idx];
      end
    end
  end

  always_comb begin
    owned_d = owned_q;
    owner_d = owner_q;
    active  = '0;
    eop     = '0;
    sel     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (pop[i] && lane_mask[i][o]) active[o] = 1'b1;
        if (last[i] && lane_mask[i][o]) begin
          eop[o]     = 1'b1;
          owned_d[o] = 1'b0;
        end
        if (grant[i] && dst[i][o]) begin
          owned_d[o] = 1'b1;
          owner_d[o] = PW'(i);
        end
      end
    end
    for (int o = 0; o < NUM_PORTS; o++)
      if (owned_q[o]) sel[o] = owner_q[o];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      owned_q <= '0;
      owner_q <= '0;
    end else begin
      rr_q    <= rr_d;
      owned_q <= owned_d;
      owner_q <= owner_d;
    end
  end

  assign bus.in_pop     = pop;
  assign bus.in_drop    = drop;
  assign bus.busy_in    = busy;
  assign bus.mux_sel    = sel;
  assign bus.out_active = active;
  assign bus.out_eop    = eop;
endmodule

// File: tb/tb_xbar_pkt_scheduler.sv
// Scoreboarded bench: the stimulus process runs a packet-level reference model and queues the
// expected per-cycle outputs; the monitor pops and compares them on the falling edge.
module tb_xbar_pkt_scheduler;
  localparam int NP = 4;
  localparam int LW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbar_pkt_scheduler_if #(.NUM_PORTS(NP), .LEN_WIDTH(LW)) bus ();
  xbar_pkt_scheduler #(.NUM_PORTS(NP), .LEN_WIDTH(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0] pop, drop, busy;
    logic [7:0] sel;
    logic [3:0] act, eop;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;

  // packet sources, one list per input
  logic [3:0] p_dst[NP][32];
  int         p_len[NP][32];
  int         p_cnt[NP], p_rd[NP], p_start[NP];

  // reference model: who owns which output, what each input still has to send
  bit         m_busy[NP];
  logic [3:0] m_mask[NP];
  int         m_rem[NP];
  int         m_own[NP];
  int         m_rr;

  int         cyc;
  bit         rst_req;
  int         frc_cnt;
  logic [3:0] frc_val;
  bit         rnd_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("in_pop",     32'(bus.in_pop),     32'(e.pop));
      chk("in_drop",    32'(bus.in_drop),    32'(e.drop));
      chk("busy_in",    32'(bus.busy_in),    32'(e.busy));
      chk("mux_sel",    32'(bus.mux_sel),    32'(e.sel));
      chk("out_active", 32'(bus.out_active), 32'(e.act));
      chk("out_eop",    32'(bus.out_eop),    32'(e.eop));
    end
  end

  task automatic model_reset();
    for (int k = 0; k < NP; k++) begin
      m_busy[k] = 1'b0; m_mask[k] = '0; m_rem[k] = 0; m_own[k] = -1;
    end
    m_rr = 0;
  endtask

  task automatic clear_src();
    for (int k = 0; k < NP; k++) begin
      p_cnt[k] = 0; p_rd[k] = 0; p_start[k] = 0;
    end
    cyc = 0;
  endtask

  task automatic add_pkt(input int i, input logic [3:0] d, input int l);
    p_dst[i][p_cnt[i]] = d;
    p_len[i][p_cnt[i]] = l;
    p_cnt[i]++;
  endtask

  function automatic logic [3:0] next_ready();
    logic [3:0] r;
    if (frc_cnt > 0) begin
      frc_cnt--;
      return frc_val;
    end
    if (!rnd_rdy) return 4'hF;
    for (int o = 0; o < NP; o++) r[o] = ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  function automatic bit all_idle();
    for (int k = 0; k < NP; k++)
      if (p_rd[k] < p_cnt[k] || m_busy[k]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of stimulus: drive inputs, predict outputs, advance the model past the edge.
  task automatic step();
    exp_t       e;
    logic [3:0] vld, rdy, req, gnt, drp, fire, taken;
    logic [15:0] df;
    logic [23:0] lf;
    int          first, i;
    @(posedge clk); #1;
    rst_n = !rst_req;
    e = '0; vld = '0; df = '0; lf = '0; req = '0; gnt = '0; drp = '0; fire = '0;
    if (rst_req) model_reset();
    else
      for (int k = 0; k < NP; k++)
        if (p_rd[k] < p_cnt[k] && !m_busy[k] && cyc >= p_start[k]) begin
          vld[k] = 1'b1;
          df[k*4+:4] = p_dst[k][p_rd[k]];
          lf[k*6+:6] = 6'(p_len[k][p_rd[k]]);
        end
    rdy = next_ready();
    bus.in_valid = vld; bus.in_dst = df; bus.in_len = lf; bus.out_ready = rdy;
    if (!rst_req) begin
      for (int k = 0; k < NP; k++) begin
        e.busy[k] = m_busy[k];
        if (m_busy[k] && (m_mask[k] & ~rdy) == 4'd0) begin
          fire[k] = 1'b1;
          e.pop[k] = 1'b1;
          e.act |= m_mask[k];
          if (m_rem[k] == 1) e.eop |= m_mask[k];
        end
        if (vld[k]) begin
          if (df[k*4+:4] == 4'd0 || lf[k*6+:6] == 6'd0) drp[k] = 1'b1;
          else req[k] = 1'b1;
        end
      end
      e.drop = drp;
      taken = '0;
      for (int o = 0; o < NP; o++)
        if (m_own[o] >= 0) begin
          taken[o] = 1'b1;
          e.sel[o*2+:2] = 2'(m_own[o]);
        end
      first = -1;
      for (int k = 0; k < NP; k++) begin
        i = (m_rr + k) % NP;
        if (req[i]) begin
          if ((df[i*4+:4] & taken) == 4'd0) begin
            gnt[i] = 1'b1;
            if (first < 0) first = i;
          end
          taken |= df[i*4+:4];
        end
      end
      for (int k = 0; k < NP; k++)
        if (fire[k]) begin
          m_rem[k]--;
          if (m_rem[k] == 0) begin
            m_busy[k] = 1'b0;
            for (int o = 0; o < NP; o++) if (m_own[o] == k) m_own[o] = -1;
          end
        end
      for (int k = 0; k < NP; k++) begin
        if (gnt[k]) begin
          m_busy[k] = 1'b1;
          m_mask[k] = df[k*4+:4];
          m_rem[k]  = int'(lf[k*6+:6]);
          for (int o = 0; o < NP; o++) if (m_mask[k][o]) m_own[o] = k;
          p_rd[k]++;
        end else if (drp[k]) p_rd[k]++;
      end
      if (first >= 0) m_rr = (first + 1) % NP;
      cyc++;
    end
    exp_q.push_back(e);
  endtask

  task automatic begin_phase();
    rst_req = 1'b1;
    step(); step();
    rst_req = 1'b0;
    clear_src();
    frc_cnt = 0;
    rnd_rdy = 1'b0;
  endtask

  task automatic run_drain(input int max_cyc);
    int n = 0;
    while (!all_idle() && n < max_cyc) begin
      step();
      n++;
    end
    n_cmp++;
    if (!all_idle()) begin
      n_bad++;
      $display("FAIL drain: still busy after %0d cycles (want idle)", n);
    end
    step(); step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    bus.in_valid = '0; bus.in_dst = '0; bus.in_len = '0; bus.out_ready = '0;
    rst_req = 1'b1; rnd_rdy = 1'b0; frc_cnt = 0; frc_val = '0;
    model_reset(); clear_src();
    step(); step();
    rst_req = 1'b0;

    // unicast
    begin_phase(); add_pkt(0, 4'b0010, 3); run_drain(50);
    // contention on output 2
    begin_phase(); add_pkt(0, 4'b0100, 2); add_pkt(2, 4'b0100, 2); run_drain(50);
    // multicast held off by output 3
    begin_phase(); add_pkt(1, 4'b1011, 2); frc_val = 4'b0111; frc_cnt = 3; run_drain(50);
    // disjoint grants in one cycle
    begin_phase(); add_pkt(0, 4'b0001, 2); add_pkt(3, 4'b1000, 2); run_drain(50);
    // blocked multicast claims ahead of later unicast
    begin_phase();
    add_pkt(0, 4'b0010, 4);
    add_pkt(1, 4'b0011, 1); p_start[1] = 1;
    add_pkt(2, 4'b0001, 1); p_start[2] = 1;
    run_drain(50);
    // illegal heads, then a legal one
    begin_phase();
    add_pkt(2, 4'b0000, 3); add_pkt(2, 4'b0101, 0); add_pkt(2, 4'b0100, 1);
    add_pkt(0, 4'b0001, 2);
    run_drain(50);
    // reset in the middle of beat 2 of a 5-beat packet
    begin_phase(); add_pkt(0, 4'b0100, 5);
    step(); step(); step();
    @(negedge clk); #2;
    rst_req = 1'b1; rst_n = 1'b0; #1;
    chk("rst_in_pop",     32'(bus.in_pop),     32'd0);
    chk("rst_busy_in",    32'(bus.busy_in),    32'd0);
    chk("rst_mux_sel",    32'(bus.mux_sel),    32'd0);
    chk("rst_out_active", 32'(bus.out_active), 32'd0);
    chk("rst_out_eop",    32'(bus.out_eop),    32'd0);
    chk("rst_in_drop",    32'(bus.in_drop),    32'd0);
    model_reset(); clear_src();
    step(); step();
    rst_req = 1'b0;
    add_pkt(1, 4'b0100, 2);
    run_drain(50);

    // randomized traffic with random backpressure
    for (int r = 0; r < 3; r++) begin
      begin_phase();
      rnd_rdy = 1'b1;
      for (int k = 0; k < NP; k++) begin
        for (int j = 0; j < 10; j++) begin
          if ($urandom_range(0, 9) == 0) d = 4'd0;
          else if ($urandom_range(0, 1) == 0) d = 4'(1 << $urandom_range(0, 3));
          else d = 4'($urandom_range(1, 15));
          add_pkt(k, d, $urandom_range(0, 5));
        end
        p_start[k] = $urandom_range(0, 5);
      end
      run_drain(3000);
    end

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
